// File: rtl/stack_sequencer_pkg.sv
// Shared types and constants for the stack PUSH/POP micro-sequencer.
package stack_seq_pkg;

    localparam int unsigned DEFAULT_SP_WIDTH = 4;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_DEC   = 3'd2,
        ST_XFER  = 3'd3,
        ST_INC   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

endpackage

// File: rtl/stack_sequencer_if.sv
// Bus between the main instruction controller and the stack sequencer.
interface stack_sequencer_if
    import stack_seq_pkg::*;
#(
    parameter int unsigned SP_WIDTH = DEFAULT_SP_WIDTH
);

    logic                start;
    logic                op;
    logic                clr_flags;
    logic                busy;
    logic                done;
    logic                err;
    logic [SP_WIDTH:0]   sp;
    logic [SP_WIDTH-1:0] sram_addr;
    logic                sram_we;
    logic                sram_re;
    logic                r1_out;
    logic                r1_in;
    logic                of_flag;
    logic                uf_flag;

    modport master (
        output start, op, clr_flags,
        input  busy, done, err, sp, sram_addr, sram_we, sram_re,
               r1_out, r1_in, of_flag, uf_flag
    );

    modport slave (
        input  start, op, clr_flags,
        output busy, done, err, sp, sram_addr, sram_we, sram_re,
               r1_out, r1_in, of_flag, uf_flag
    );

endinterface

// File: rtl/stack_sequencer_sp_counter.sv
// Stack pointer: saturating up/down entry counter with full/empty decode.
module sp_counter #(
    parameter int unsigned SP_WIDTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [SP_WIDTH:0] sp,
    output logic              full,
    output logic              empty
);

    localparam int unsigned DEPTH = 1 << SP_WIDTH;

    assign full  = (sp == (SP_WIDTH+1)'(DEPTH));
    assign empty = (sp == '0);

    // Saturation is a backstop; the FSM never requests a step past a boundary.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (inc && !full) begin
            sp <= sp + (SP_WIDTH+1)'(1);
        end else if (dec && !empty) begin
            sp <= sp - (SP_WIDTH+1)'(1);
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// PUSH/POP micro-sequencer owning the shared bus for stack SRAM transfers.
// Optional sticky overflow/underflow flags: define STACK_SEQ_STICKY_FLAGS_EN.
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int unsigned SP_WIDTH = DEFAULT_SP_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    stack_sequencer_if.slave    bus
);

    state_e              state_q;
    state_e              state_d;
    logic                op_q;
    logic [SP_WIDTH:0]   sp;
    logic                full;
    logic                empty;
    logic                xfer;

    sp_counter #(
        .SP_WIDTH (SP_WIDTH)
    ) u_sp_counter (
        .clock (clock),
        .reset (reset),
        .inc   (state_q == ST_INC),
        .dec   (state_q == ST_DEC),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    // State and latched opcode; op is captured only on an accepted start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_POP;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.start) begin
                op_q <= bus.op;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_CHECK;
            ST_CHECK: begin
                if (op_q == OP_PUSH) state_d = full  ? ST_ERR : ST_XFER;
                else                 state_d = empty ? ST_ERR : ST_DEC;
            end
            ST_DEC:   state_d = ST_XFER;
            ST_XFER:  state_d = (op_q == OP_PUSH) ? ST_INC : ST_DONE;
            ST_INC:   state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the state register directly, so reset removes them at once.
    assign xfer          = (state_q == ST_XFER);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign bus.err       = (state_q == ST_ERR);
    assign bus.sram_we   = xfer && (op_q == OP_PUSH);
    assign bus.r1_out    = xfer && (op_q == OP_PUSH);
    assign bus.sram_re   = xfer && (op_q == OP_POP);
    assign bus.r1_in     = xfer && (op_q == OP_POP);
    assign bus.sram_addr = sp[SP_WIDTH-1:0];
    assign bus.sp        = sp;

`ifdef STACK_SEQ_STICKY_FLAGS_EN
    logic of_q;
    logic uf_q;

    // Set on the edge that leaves ERR; a simultaneous clear loses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            of_q <= 1'b0;
            uf_q <= 1'b0;
        end else begin
            if (state_q == ST_ERR && op_q == OP_PUSH) of_q <= 1'b1;
            else if (bus.clr_flags)                   of_q <= 1'b0;
            if (state_q == ST_ERR && op_q == OP_POP)  uf_q <= 1'b1;
            else if (bus.clr_flags)                   uf_q <= 1'b0;
        end
    end

    assign bus.of_flag = of_q;
    assign bus.uf_flag = uf_q;
`else
    logic unused_clr_flags;

    assign unused_clr_flags = bus.clr_flags;
    assign bus.of_flag      = 1'b0;
    assign bus.uf_flag      = 1'b0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a small SRAM/R1 data model.
module tb_stack_sequencer;
    import stack_seq_pkg::*;

`ifdef STACK_SEQ_STICKY_FLAGS_EN
    localparam logic FLAGS_EN = 1'b1;
`else
    localparam logic FLAGS_EN = 1'b0;
`endif

    logic clock;
    logic reset;

    stack_sequencer_if #(.SP_WIDTH(4)) bus ();

    stack_sequencer #(.SP_WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM and R1 model: write captured on the clock low phase
    logic [7:0] mem [16];
    logic [7:0] push_data;
    logic [7:0] pop_data;

    always @(negedge clock) begin
        if (bus.sram_we && bus.r1_out) mem[bus.sram_addr] <= push_data;
        if (bus.sram_re && bus.r1_in)  pop_data <= mem[bus.sram_addr];
    end

    int         r_lat;
    logic       r_err;
    logic [3:0] r_addr;
    logic       r_we, r_re, r_ro, r_ri, r_excl;

    // Issue one operation from IDLE (#1 after an edge) and observe until done.
    task automatic run_op(input logic o, input bit glitch);
        bus.op    = o;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.op    = ~o;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        r_lat = 0; r_err = 1'b0; r_addr = '0;
        r_we = 1'b0; r_re = 1'b0; r_ro = 1'b0; r_ri = 1'b0; r_excl = 1'b1;
        for (int k = 1; k <= 10 && r_lat == 0; k++) begin
            if (glitch && (k == 1 || k == 2)) begin
                bus.start = 1'b1;
                bus.op    = OP_PUSH;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock); #1;
            if (bus.sram_we || bus.sram_re) r_addr = bus.sram_addr;
            r_we |= bus.sram_we;
            r_re |= bus.sram_re;
            r_ro |= bus.r1_out;
            r_ri |= bus.r1_in;
            if ((bus.sram_we && bus.sram_re) || (bus.r1_out && bus.r1_in)) r_excl = 1'b0;
            if (bus.done) begin
                r_lat = k;
                r_err = bus.err;
                check("busy_in_done", 32'(bus.busy), 32'd1);
            end
        end
        bus.start = 1'b0;
        @(posedge clock); #1;
        check("idle_after_done", 32'(bus.busy), 32'd0);
    endtask

    task automatic push_ok(input logic [7:0] data, input logic [3:0] exp_addr);
        push_data = data;
        run_op(OP_PUSH, 1'b0);
        check("push_latency", 32'(r_lat), 32'd3);
        check("push_err", 32'(r_err), 32'd0);
        check("push_addr", 32'(r_addr), 32'(exp_addr));
        check("push_strobes", {28'd0, r_we, r_ro, r_re, r_ri}, 32'b1100);
        check("push_excl", 32'(r_excl), 32'd1);
        check("push_mem", 32'(mem[exp_addr]), 32'(data));
    endtask

    task automatic pop_ok(input logic [3:0] exp_addr, input logic [7:0] exp_data);
        run_op(OP_POP, 1'b0);
        check("pop_latency", 32'(r_lat), 32'd3);
        check("pop_err", 32'(r_err), 32'd0);
        check("pop_addr", 32'(r_addr), 32'(exp_addr));
        check("pop_strobes", {28'd0, r_we, r_ro, r_re, r_ri}, 32'b0011);
        check("pop_excl", 32'(r_excl), 32'd1);
        check("pop_data", 32'(pop_data), 32'(exp_data));
    endtask

    task automatic op_err(input logic o);
        run_op(o, 1'b0);
        check("err_latency", 32'(r_lat), 32'd1);
        check("err_flag", 32'(r_err), 32'd1);
        check("err_no_strobes", {28'd0, r_we, r_ro, r_re, r_ri}, 32'd0);
    endtask

    int extra_done;

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 1'b0;
        bus.clr_flags = 1'b0;
        push_data     = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_outputs", {24'd0, bus.busy, bus.done, bus.err, bus.sram_we,
              bus.sram_re, bus.r1_out, bus.r1_in, bus.of_flag}, 32'd0);
        check("rst_uf", 32'(bus.uf_flag), 32'd0);
        check("rst_sp", 32'(bus.sp), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // First PUSH of R1 = A5 lands at address 0
        push_ok(8'hA5, 4'd0);
        check("sp_after_push1", 32'(bus.sp), 32'd1);

        push_ok(8'hB6, 4'd1);
        push_ok(8'hC7, 4'd2);
        check("sp_after_push3", 32'(bus.sp), 32'd3);
        pop_ok(4'd2, 8'hC7);
        pop_ok(4'd1, 8'hB6);
        pop_ok(4'd0, 8'hA5);
        check("sp_after_pops", 32'(bus.sp), 32'd0);

        // Underflow
        op_err(OP_POP);
        check("uf_sp", 32'(bus.sp), 32'd0);
        check("uf_flag", 32'(bus.uf_flag), 32'(FLAGS_EN));
        check("uf_no_of", 32'(bus.of_flag), 32'd0);

        // Fill to 16, then overflow
        for (int i = 0; i < 16; i++) begin
            push_ok(8'(8'h10 + i), 4'(i));
            check("sp_fill", 32'(bus.sp), 32'(i + 1));
        end
        op_err(OP_PUSH);
        check("of_sp", 32'(bus.sp), 32'd16);
        check("of_flag", 32'(bus.of_flag), 32'(FLAGS_EN));
        check("uf_still_set", 32'(bus.uf_flag), 32'(FLAGS_EN));

        bus.clr_flags = 1'b1;
        @(posedge clock); #1;
        bus.clr_flags = 1'b0;
        check("clr_of", 32'(bus.of_flag), 32'd0);
        check("clr_uf", 32'(bus.uf_flag), 32'd0);

        // Clear held across the setting edge: set wins
        bus.clr_flags = 1'b1;
        op_err(OP_PUSH);
        check("set_beats_clr", 32'(bus.of_flag), 32'(FLAGS_EN));
        bus.clr_flags = 1'b0;

        // Starts during an active PUSH are ignored
        pop_ok(4'd15, 8'h1F);
        check("sp_15", 32'(bus.sp), 32'd15);
        push_data = 8'h77;
        run_op(OP_PUSH, 1'b1);
        check("glitch_latency", 32'(r_lat), 32'd3);
        check("glitch_addr", 32'(r_addr), 32'd15);
        extra_done = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.done || bus.busy) extra_done++;
            @(posedge clock); #1;
        end
        check("glitch_no_extra", 32'(extra_done), 32'd0);
        check("glitch_sp", 32'(bus.sp), 32'd16);

        // Reset in the middle of a POP transfer
        bus.op    = OP_POP;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 5 && !bus.sram_re; k++) begin
            @(posedge clock); #1;
        end
        check("pop_xfer_reached", 32'(bus.sram_re), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_strobes", {28'd0, bus.sram_we, bus.sram_re, bus.r1_out, bus.r1_in}, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_flush_sp", 32'(bus.sp), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        push_ok(8'h5A, 4'd0);
        check("sp_after_rst_push", 32'(bus.sp), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Micro-sequencer for PUSH/POP on the processor's stack SRAM. On a one-cycle `start` from the main instruction controller, it owns the shared bus for a fixed sequence and maintains the stack pointer. It detects overflow and underflow before any SRAM access, then returns `done` so the main controller can issue END/PCinc. It replaces hand-coded PUSH/POP T-steps with a dedicated FSM beside the register file and stack SRAM.

## Interface
Parameters:
- `SP_WIDTH`, 4: address bits; stack depth DEPTH = 2**SP_WIDTH entries.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  1  1 = PUSH, 0 = POP; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`; 1 = overflow (PUSH) or underflow (POP), no transfer made.
- `sp`  out  SP_WIDTH+1  entry count, 0..DEPTH.
- `sram_addr`  out  SP_WIDTH  stack SRAM address.
- `sram_we`  out  1  stack SRAM write strobe (SRin).
- `sram_re`  out  1  stack SRAM drive-to-bus (SRout).
- `r1_out`  out  1  register file drives R1 onto bus (Gro·R1out).
- `r1_in`  out  1  register file latches bus into R1 (Gri·R1in).
- `of_flag`, `uf_flag`  out  1  sticky status (see Configuration).
- `clr_flags`  in  1  clears sticky flags.

## Operation
- FSM states: IDLE, CHECK, DEC, XFER, INC, DONE, ERR.
- IDLE → CHECK on `start`; `op` is latched into an internal op register at the same edge.
- CHECK, PUSH: if sp == DEPTH, go to ERR; else go to XFER.
- CHECK, POP: if sp == 0, go to ERR; else go to DEC.
- DEC: sp ← sp − 1; then XFER.
- XFER, PUSH:
  - `r1_out`=1, `sram_we`=1, `sram_addr`=sp[SP_WIDTH-1:0].
  - Next state: INC.
- XFER, POP:
  - `sram_re`=1, `r1_in`=1, `sram_addr`=sp[SP_WIDTH-1:0], using the already-decremented value.
  - Next state: DONE.
- INC: sp ← sp + 1; then DONE.
- DONE: `done`=1, `err`=0; then IDLE.
- ERR: `done`=1, `err`=1; sp unchanged, no strobe asserted; then IDLE.
- Strobes are a pure decode of the state register plus the latched op.
  - At most one of `sram_we`/`sram_re` is high in any cycle.
  - At most one of `r1_out`/`r1_in` is high in any cycle.
- `sram_addr` = sp[SP_WIDTH-1:0] in all states; it is meaningful only in XFER.
- `start` outside IDLE is ignored (no queueing).
- `op` changes after the start cycle have no effect.

## Timing
- Reset values: state IDLE, sp=0, latched op=0, and every output 0 (`busy`, `done`, `err`, strobes, flags).
- Reset asserted mid-sequence aborts it at once:
  - Strobes drop asynchronously.
  - sp returns to 0, i.e. the stack is flushed.
- Latency, counting `start` sampled at edge 0:
  - PUSH: CHECK, XFER, INC, DONE; `done` is high in the cycle after edge 3.
  - POP: CHECK, DEC, XFER, DONE; `done` is high in the cycle after edge 3.
  - Error: CHECK, ERR; `done`/`err` are high in the cycle after edge 1.
- `busy` rises the cycle after the `start` edge.
- `busy` is still high during the DONE/ERR cycle.
- A new `start` is accepted in the cycle after DONE/ERR, giving back-to-back operations 5 cycles apart.
- The SRAM write is captured on the `clock` low phase outside this block; strobes are stable for the whole XFER cycle.
- Boundaries:
  - PUSH at sp = DEPTH−1 succeeds, giving sp = DEPTH.
  - POP at sp = 1 gives sp = 0.
  - sp never wraps.

## Configuration
- `STACK_SEQ_STICKY_FLAGS_EN` defined:
  - `of_flag` sets on ERR for a PUSH; `uf_flag` sets on ERR for a POP.
  - Both hold until `clr_flags` or `reset`.
  - If `clr_flags` and a set event occur on the same edge, set wins.
- Macro undefined:
  - `of_flag`/`uf_flag` are tied to 0 and `clr_flags` is ignored.
  - Port list unchanged.

## Structure
- Package `stack_seq_pkg`: state enum; `OP_PUSH`=1'b1, `OP_POP`=1'b0; default `SP_WIDTH`.
- Sub-module `sp_counter`:
  - SP_WIDTH+1-bit up/down counter with async reset.
  - Combinational `full` (sp == DEPTH) and `empty` (sp == 0).
  - Instantiated once.

## Test plan
- Reset, then PUSH with R1 modelled as 8'hA5: XFER shows sram_addr=0, sram_we=1, r1_out=1; `done` 4 cycles after start; sp=1, err=0.
- PUSH ×3, then POP ×3: POP XFER addresses are 2, 1, 0 with sram_re=1 and r1_in=1; final sp=0.
- POP at sp=0: `done`=`err`=1 two cycles after start; no strobes; sp=0; uf_flag=1 with macro defined, 0 without.
- Fill to DEPTH=16, then PUSH: err=1, sp stays 16, of_flag=1; `clr_flags` clears it; same-edge set+clear leaves it 1.
- `start` pulsed during an active PUSH: ignored; exactly one `done`; sp increments by 1 only.
- Reset asserted during a POP XFER: strobes drop immediately, sp=0, state IDLE; next PUSH writes address 0.
